// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program-image loader.
// The memory geometry constants are also reused by the memory and the address mux.
package prog_loader_pkg;

  localparam int MEM_DEPTH = 32;
  localparam int ADDR_W    = 5;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t IDLE  = 3'd0;
  localparam loader_state_t LEN   = 3'd1;
  localparam loader_state_t DATA  = 3'd2;
  localparam loader_state_t WRITE = 3'd3;
  localparam loader_state_t CSUM  = 3'd4;
  localparam loader_state_t DONE  = 3'd5;
  localparam loader_state_t ERROR = 3'd6;

endpackage

// File: rtl/prog_loader_counter.sv
// Loadable up-counter used as the loader's memory write address.
// A load takes priority over an increment.
module prog_loader_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (enable)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream (LEN, LEN data bytes, CSUM) into instruction memory
// from address 0, holding the CPU until a frame arrives with a matching checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter bit HOLD_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  loader_state_t     state;
  logic [5:0]        remaining;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              len_ok;

  assign xfer   = byte_valid && byte_ready;
  assign len_ok = (byte_data != 8'd0) && (byte_data <= 8'(MEM_DEPTH));

  // Handshake and status outputs are pure state decodes, never combinational on byte_valid.
  assign byte_ready = (state == LEN) || (state == DATA) || (state == CSUM);
  assign mem_wr     = (state == WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);

  prog_loader_counter #(
    .WIDTH(ADDR_W)
  ) u_addr_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (state == LEN),
    .load_value ({ADDR_W{1'b0}}),
    .enable     (state == WRITE),
    .count      (addr)
  );

  // mem_addr is latched from the counter on the data transfer so it stays put
  // while the counter advances after the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_hold  <= HOLD_ON_RESET;
      remaining <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN;
            cpu_hold <= 1'b1;
          end
        end
        LEN: begin
          if (xfer) begin
            if (len_ok) begin
              remaining <= byte_data[5:0];
              sum       <= '0;
              state     <= DATA;
            end else begin
              state <= ERROR;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            mem_data <= byte_data;
            mem_addr <= addr;
            sum      <= sum + byte_data;
            state    <= WRITE;
          end
        end
        WRITE: begin
          remaining <= remaining - 6'd1;
          state     <= (remaining == 6'd1) ? CSUM : DATA;
        end
        CSUM: begin
          if (xfer) begin
            if (byte_data == sum) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are checked against a
// frame-level model of the expected memory writes and final status.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [12:0] obs_w[$];
  logic [12:0] exp_w[$];
  logic [12:0] saved_w[$];
  bit          exp_done;
  logic [7:0]  frm[$];

  prog_loader #(.HOLD_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr === 1'b1) obs_w.push_back({mem_addr, mem_data});
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Frame-level reference: data byte i lands at address i; done iff CSUM equals the byte sum.
  task automatic model_frame(input logic [7:0] f[$]);
    int len;
    logic [7:0] s;
    exp_w.delete();
    exp_done = 1'b0;
    len = int'(f[0]);
    s = 8'd0;
    if (len < 1 || len > 32) return;
    for (int i = 0; i < len; i++) begin
      exp_w.push_back({5'(i), f[1+i]});
      s = s + f[1+i];
    end
    exp_done = (f[len+1] == s);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noisy);
    int n;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    if (noisy) start = 1'($urandom_range(0, 1));
    n = 0;
    while (byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] f[$], input int max_gap, input bit noisy,
                           input string name, output int elapsed);
    int t0;
    model_frame(f);
    @(negedge clk);
    obs_w.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    total++;
    if ({cpu_hold, done, error} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL %s_enter_len: hold/done/error=%b required 100", name, {cpu_hold, done, error});
    end
    foreach (f[i]) send_byte(f[i], max_gap, noisy);
    elapsed = cyc - t0;
    total++;
    if (done !== exp_done) begin
      bad++;
      $display("[TB] FAIL %s_done: got %b required %b", name, done, exp_done);
    end
    total++;
    if (error !== !exp_done) begin
      bad++;
      $display("[TB] FAIL %s_error: got %b required %b", name, error, !exp_done);
    end
    total++;
    if (cpu_hold !== !exp_done) begin
      bad++;
      $display("[TB] FAIL %s_hold: got %b required %b", name, cpu_hold, !exp_done);
    end
    total++;
    if (obs_w.size() != exp_w.size()) begin
      bad++;
      $display("[TB] FAIL %s_write_count: got %0d required %0d", name, obs_w.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        total++;
        if (obs_w[i] !== exp_w[i]) begin
          bad++;
          $display("[TB] FAIL %s_write%0d: addr/data got %0d/%h required %0d/%h", name, i,
                   obs_w[i][12:8], obs_w[i][7:0], exp_w[i][12:8], exp_w[i][7:0]);
        end
      end
    end
  endtask

  task automatic make_random_frame(input int len, input bit corrupt);
    logic [7:0] s;
    frm.delete();
    frm.push_back(8'(len));
    s = 8'd0;
    for (int i = 0; i < len; i++) begin
      frm.push_back(8'($urandom));
      s = s + frm[frm.size()-1];
    end
    frm.push_back(corrupt ? s + 8'(1 + $urandom_range(0, 254)) : s);
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({byte_ready, mem_wr, done, error, mem_addr, mem_data, cpu_hold} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL %s: rdy/wr/done/err/addr/data/hold got %b/%b/%b/%b/%0d/%h/%b required 0/0/0/0/0/00/1",
               name, byte_ready, mem_wr, done, error, mem_addr, mem_data, cpu_hold);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #2;
    check_reset_outputs("reset_values");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (byte_ready !== 1'b0 || mem_wr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: ready/wr got %b/%b required 0/0", byte_ready, mem_wr);
    end
  endtask

  task automatic test_good_frame();
    int el;
    frm = '{8'd3, 8'hA1, 8'h02, 8'h45, 8'hE8};
    run_frame(frm, 0, 1'b0, "good_frame", el);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL good_frame_const_done: got %b required 1", done);
    end
  endtask

  task automatic test_bad_checksum();
    int el;
    frm = '{8'd3, 8'hA1, 8'h02, 8'h45, 8'hE7};
    run_frame(frm, 0, 1'b0, "bad_csum", el);
    total++;
    if ({done, error, cpu_hold} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL bad_csum_const: done/err/hold got %b required 011", {done, error, cpu_hold});
    end
  endtask

  task automatic test_illegal_len();
    int el;
    frm = '{8'd0};
    run_frame(frm, 0, 1'b0, "len0", el);
    frm = '{8'd33};
    run_frame(frm, 0, 1'b0, "len33", el);
    frm = '{8'($urandom_range(34, 255))};
    run_frame(frm, 2, 1'b0, "len_big", el);
  endtask

  task automatic test_full_image();
    int el;
    frm.delete();
    frm.push_back(8'd32);
    for (int i = 0; i < 32; i++) frm.push_back(8'(i));
    frm.push_back(8'hF0);
    run_frame(frm, 0, 1'b0, "full_image", el);
    total++;
    if (obs_w.size() != 32 || obs_w[31] !== {5'd31, 8'd31}) begin
      bad++;
      $display("[TB] FAIL full_image_last: writes=%0d required 32 ending at addr 31", obs_w.size());
    end
  endtask

  task automatic test_flow_control();
    int el;
    make_random_frame($urandom_range(4, 20), 1'b0);
    run_frame(frm, 0, 1'b0, "flow_ref", el);
    saved_w = obs_w;
    run_frame(frm, 5, 1'b1, "flow_gaps", el);
    total++;
    if (obs_w != saved_w) begin
      bad++;
      $display("[TB] FAIL flow_same_writes: gapped writes=%0d gap-free writes=%0d or contents differ",
               obs_w.size(), saved_w.size());
    end
  endtask

  task automatic test_random_frames();
    int el;
    for (int k = 0; k < 6; k++) begin
      make_random_frame($urandom_range(1, 32), 1'($urandom_range(0, 1)));
      run_frame(frm, 3, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k), el);
    end
  endtask

  task automatic test_back_to_back();
    int el;
    int len;
    for (int k = 0; k < 2; k++) begin
      len = $urandom_range(1, 32);
      make_random_frame(len, 1'b0);
      run_frame(frm, 0, 1'b0, $sformatf("b2b%0d", k), el);
      total++;
      if (el != 2 * len + 2) begin
        bad++;
        $display("[TB] FAIL b2b%0d_cycles: got %0d required %0d", k, el, 2 * len + 2);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int el;
    int n;
    logic [7:0] d0;
    logic [7:0] d1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    @(negedge clk);
    obs_w.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd4, 0, 1'b0);
    send_byte(d0, 0, 1'b0);
    byte_valid = 1'b1;
    byte_data = d1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_frame");
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (obs_w.size() != 1 || obs_w[0] !== {5'd0, d0}) begin
      bad++;
      $display("[TB] FAIL reset_no_more_writes: writes=%0d required 1 (addr 0 data %h)", obs_w.size(), d0);
    end
    total++;
    if ({byte_ready, done, error, cpu_hold} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL reset_idle: rdy/done/err/hold got %b required 0001",
               {byte_ready, done, error, cpu_hold});
    end
    make_random_frame($urandom_range(1, 16), 1'b0);
    run_frame(frm, 1, 1'b0, "after_reset", el);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_illegal_len();
    test_full_image();
    test_flow_control();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
